// File: rtl/dual_port_ram_pkg.sv
// Shared constants and helpers for the byte-enabled true dual-port RAM family.
// Imported by the RAM top and its per-port read pipeline.
package dual_port_ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  // Widest word / lane count the merge helper can serve.
  localparam int MAX_DATA_W = 512;
  localparam int MAX_NB     = 64;

  typedef logic [MAX_DATA_W-1:0] word_t;
  typedef logic [MAX_NB-1:0]     lanes_t;

  // Read latency in cycles: one for the array read, plus the optional output register.
  function automatic int lat(input int out_reg);
    return (out_reg != 0) ? 2 : 1;
  endfunction

  // Lanes with be set take new_word, the rest keep old_word.
  function automatic word_t merge_bytes(input word_t  old_word,
                                        input word_t  new_word,
                                        input lanes_t be,
                                        input int     byte_w);
    word_t      merged;
    logic [5:0] lane;
    merged = old_word;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      lane = 6'((i / byte_w) % MAX_NB);
      if (be[lane]) begin
        merged[i] = new_word[i];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dual_port_ram_rdpipe.sv
// Per-port read-return pipeline of depth LAT: data/valid stages that hold data
// while idle and flush synchronously on reset.
module dual_port_ram_rdpipe
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out
);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;

  // Data is only captured alongside a valid return, so idle cycles keep the last word.
  always_comb begin
    s1_valid_d = valid_in;
    s1_data_d  = valid_in ? data_in : s1_data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q,  s2_data_d;

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign valid_out = s2_valid_q;
    assign data_out  = s2_data_q;
  end else begin : g_no_out_reg
    assign valid_out = s1_valid_q;
    assign data_out  = s1_data_q;
  end

endmodule

// File: rtl/dual_port_ram_be.sv
// Parametrised true dual-port synchronous RAM with per-byte write enables,
// selectable read-during-write behaviour, optional output register and collision flags.
module dual_port_ram_be
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int BYTE_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0,
  parameter int COLL_PRI = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en_a,
  input  logic                       we_a,
  input  logic [DATA_W/BYTE_W-1:0]   be_a,
  input  logic [ADDR_W-1:0]          addr_a,
  input  logic [DATA_W-1:0]          wdata_a,
  output logic [DATA_W-1:0]          rdata_a,
  output logic                       rvalid_a,
  input  logic                       en_b,
  input  logic                       we_b,
  input  logic [DATA_W/BYTE_W-1:0]   be_b,
  input  logic [ADDR_W-1:0]          addr_b,
  input  logic [DATA_W-1:0]          wdata_b,
  output logic [DATA_W-1:0]          rdata_b,
  output logic                       rvalid_b,
  output logic                       coll,
  output logic                       coll_sticky
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LAT   = lat(OUT_REG);

  if (BYTE_W < 1) begin : g_bad_byte_w
    $error("dual_port_ram_be: BYTE_W must be at least 1");
  end else if (DATA_W % BYTE_W != 0) begin : g_bad_data_w
    $error("dual_port_ram_be: DATA_W must be a multiple of BYTE_W");
  end
  if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_rdw
    $error("dual_port_ram_be: RDW_MODE must be 0, 1 or 2");
  end
  if (DATA_W > MAX_DATA_W || NB > MAX_NB) begin : g_too_wide
    $error("dual_port_ram_be: word wider than merge helper supports");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              acc_a, acc_b, wr_a, wr_b, same_addr, coll_now;
  logic [NB-1:0]     lanes_a, lanes_b;
  logic [DATA_W-1:0] ret_a, ret_b;
  logic              ret_valid_a, ret_valid_b;

  function automatic logic [DATA_W-1:0] merged_word(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] new_word,
                                                     input logic [NB-1:0]     be);
    return DATA_W'(merge_bytes(word_t'(old_word), word_t'(new_word), lanes_t'(be), BYTE_W));
  endfunction

  // Lane arbitration: a lane enabled on both ports at the same address goes only
  // to the priority port; the collision is judged before that masking.
  always_comb begin
    acc_a     = en_a && !reset;
    acc_b     = en_b && !reset;
    wr_a      = acc_a && we_a;
    wr_b      = acc_b && we_b;
    same_addr = (addr_a == addr_b);
    lanes_a   = wr_a ? be_a : '0;
    lanes_b   = wr_b ? be_b : '0;
    coll_now  = same_addr && (|(lanes_a & lanes_b));
    if (same_addr) begin
      if (COLL_PRI == 0) begin
        lanes_b = lanes_b & ~lanes_a;
      end else begin
        lanes_a = lanes_a & ~lanes_b;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++) begin
      if (lanes_a[i]) begin
        mem_q[addr_a][i*BYTE_W +: BYTE_W] <= wdata_a[i*BYTE_W +: BYTE_W];
      end
      if (lanes_b[i]) begin
        mem_q[addr_b][i*BYTE_W +: BYTE_W] <= wdata_b[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Returned word per port; reads always see the pre-edge contents of the array.
  always_comb begin
    ret_a       = mem_q[addr_a];
    ret_valid_a = acc_a;
    if (wr_a) begin
      if (RDW_MODE == RDW_WRITE_FIRST) begin
        ret_a = merged_word(mem_q[addr_a], wdata_a, be_a);
      end else if (RDW_MODE == RDW_NO_CHANGE) begin
        ret_valid_a = 1'b0;
      end
    end
  end

  always_comb begin
    ret_b       = mem_q[addr_b];
    ret_valid_b = acc_b;
    if (wr_b) begin
      if (RDW_MODE == RDW_WRITE_FIRST) begin
        ret_b = merged_word(mem_q[addr_b], wdata_b, be_b);
      end else if (RDW_MODE == RDW_NO_CHANGE) begin
        ret_valid_b = 1'b0;
      end
    end
  end

  dual_port_ram_rdpipe #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_pipe_a (
    .clock     (clock),
    .reset     (reset),
    .valid_in  (ret_valid_a),
    .data_in   (ret_a),
    .valid_out (rvalid_a),
    .data_out  (rdata_a)
  );

  dual_port_ram_rdpipe #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_pipe_b (
    .clock     (clock),
    .reset     (reset),
    .valid_in  (ret_valid_b),
    .data_in   (ret_b),
    .valid_out (rvalid_b),
    .data_out  (rdata_b)
  );

  logic coll_s1_q, coll_s1_d;
  logic coll_q, coll_d;
  logic coll_sticky_q, coll_sticky_d;

  // The collision flag travels alongside the read returns so it lines up with rvalid.
  always_comb begin
    coll_s1_d     = coll_now;
    coll_d        = (LAT == 2) ? coll_s1_q : coll_now;
    coll_sticky_d = coll_sticky_q | coll_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      coll_s1_q     <= 1'b0;
      coll_q        <= 1'b0;
      coll_sticky_q <= 1'b0;
    end else begin
      coll_s1_q     <= coll_s1_d;
      coll_q        <= coll_d;
      coll_sticky_q <= coll_sticky_d;
    end
  end

  assign coll        = coll_q;
  assign coll_sticky = coll_sticky_q;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench driving three RAM configurations in lockstep:
// dut0 READ_FIRST/LAT1/prio A, dut1 WRITE_FIRST/LAT2/prio B, dut2 NO_CHANGE/LAT1/prio A.
module tb_dual_port_ram_be;
  import dual_port_ram_pkg::*;

  localparam int NDUT = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  be_a, be_b;
  logic [5:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;

  logic [31:0] rdata_a [NDUT];
  logic [31:0] rdata_b [NDUT];
  logic        rvalid_a [NDUT];
  logic        rvalid_b [NDUT];
  logic        coll [NDUT];
  logic        coll_sticky [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dual_port_ram_be #(.DATA_W(32), .BYTE_W(8), .ADDR_W(6), .RDW_MODE(RDW_READ_FIRST),
                     .OUT_REG(0), .COLL_PRI(0)) dut0 (
    .clock(clock), .reset(reset),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a[0]), .rvalid_a(rvalid_a[0]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b[0]), .rvalid_b(rvalid_b[0]),
    .coll(coll[0]), .coll_sticky(coll_sticky[0]));

  dual_port_ram_be #(.DATA_W(32), .BYTE_W(8), .ADDR_W(6), .RDW_MODE(RDW_WRITE_FIRST),
                     .OUT_REG(1), .COLL_PRI(1)) dut1 (
    .clock(clock), .reset(reset),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a[1]), .rvalid_a(rvalid_a[1]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b[1]), .rvalid_b(rvalid_b[1]),
    .coll(coll[1]), .coll_sticky(coll_sticky[1]));

  dual_port_ram_be #(.DATA_W(32), .BYTE_W(8), .ADDR_W(6), .RDW_MODE(RDW_NO_CHANGE),
                     .OUT_REG(0), .COLL_PRI(0)) dut2 (
    .clock(clock), .reset(reset),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a[2]), .rvalid_a(rvalid_a[2]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b[2]), .rvalid_b(rvalid_b[2]),
    .coll(coll[2]), .coll_sticky(coll_sticky[2]));

  task automatic drive_a(input logic en, input logic we, input logic [3:0] be,
                         input logic [5:0] addr, input logic [31:0] data);
    en_a = en; we_a = we; be_a = be; addr_a = addr; wdata_a = data;
  endtask

  task automatic drive_b(input logic en, input logic we, input logic [3:0] be,
                         input logic [5:0] addr, input logic [31:0] data);
    en_b = en; we_b = we; be_b = be; addr_b = addr; wdata_b = data;
  endtask

  task automatic idle();
    drive_a(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
    drive_b(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if ({rvalid_a[d], rvalid_b[d], coll[d], coll_sticky[d]} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_flags dut%0d got %b exp 0000", d,
                 {rvalid_a[d], rvalid_b[d], coll[d], coll_sticky[d]});
      end
      checks++;
      if (rdata_a[d] !== 32'h0 || rdata_b[d] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_rdata dut%0d got %h/%h exp 0/0", d, rdata_a[d], rdata_b[d]);
      end
    end
  endtask

  task automatic test_latency();
    logic        ev [NDUT];
    logic [31:0] ed [NDUT];
    drive_a(1'b1, 1'b1, 4'hF, 6'd5, 32'h000000A5);
    tick();
    drive_a(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
    drive_b(1'b1, 1'b0, 4'h0, 6'd5, 32'h0);
    tick();
    idle();
    ev = '{1'b1, 1'b0, 1'b1};
    ed = '{32'hA5, 32'h0, 32'hA5};
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rvalid_b[d] !== ev[d] || rdata_b[d] !== ed[d]) begin
        errors++;
        $display("[TB] FAIL latency_first dut%0d got v=%0b d=%h exp v=%0b d=%h",
                 d, rvalid_b[d], rdata_b[d], ev[d], ed[d]);
      end
    end
    tick();
    ev = '{1'b0, 1'b1, 1'b0};
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rvalid_b[d] !== ev[d] || rdata_b[d] !== 32'hA5) begin
        errors++;
        $display("[TB] FAIL latency_second dut%0d got v=%0b d=%h exp v=%0b d=000000a5",
                 d, rvalid_b[d], rdata_b[d], ev[d]);
      end
    end
    tick();
    checks++;
    if (rvalid_b[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_single_pulse dut1 got %0b exp 0", rvalid_b[1]);
    end
  endtask

  task automatic test_byte_enables();
    logic        ev [NDUT];
    logic [31:0] ed [NDUT];
    drive_a(1'b1, 1'b1, 4'hF, 6'd3, 32'h11223344);
    tick();
    drive_a(1'b1, 1'b1, 4'b0101, 6'd3, 32'hAABBCCDD);
    tick();
    ev = '{1'b1, 1'b1, 1'b0};
    ed = '{32'h11223344, 32'h11223344, 32'h0};
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rvalid_a[d] !== ev[d] || rdata_a[d] !== ed[d]) begin
        errors++;
        $display("[TB] FAIL be_write_return dut%0d got v=%0b d=%h exp v=%0b d=%h",
                 d, rvalid_a[d], rdata_a[d], ev[d], ed[d]);
      end
    end
    drive_a(1'b1, 1'b0, 4'h0, 6'd3, 32'h0);
    tick();
    idle();
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rvalid_a[d] !== 1'b1 || rdata_a[d] !== 32'h11BB33DD) begin
        errors++;
        $display("[TB] FAIL be_merge dut%0d got v=%0b d=%h exp v=1 d=11bb33dd",
                 d, rvalid_a[d], rdata_a[d]);
      end
    end
    tick();
    checks++;
    if (rvalid_a[1] !== 1'b1 || rdata_a[1] !== 32'h11BB33DD) begin
      errors++;
      $display("[TB] FAIL be_merge_read dut1 got v=%0b d=%h exp v=1 d=11bb33dd",
               rvalid_a[1], rdata_a[1]);
    end
  endtask

  task automatic test_rdw_modes();
    logic        ev [NDUT];
    logic [31:0] ed [NDUT];
    drive_a(1'b1, 1'b1, 4'hF, 6'd7, 32'h10);
    tick();
    drive_a(1'b1, 1'b1, 4'hF, 6'd7, 32'h20);
    tick();
    idle();
    ev = '{1'b1, 1'b1, 1'b0};
    ed = '{32'h10, 32'h10, 32'h11BB33DD};
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rvalid_a[d] !== ev[d] || rdata_a[d] !== ed[d]) begin
        errors++;
        $display("[TB] FAIL rdw_return dut%0d got v=%0b d=%h exp v=%0b d=%h",
                 d, rvalid_a[d], rdata_a[d], ev[d], ed[d]);
      end
    end
    tick();
    checks++;
    if (rvalid_a[1] !== 1'b1 || rdata_a[1] !== 32'h20) begin
      errors++;
      $display("[TB] FAIL rdw_write_first dut1 got v=%0b d=%h exp v=1 d=00000020",
               rvalid_a[1], rdata_a[1]);
    end
    drive_a(1'b1, 1'b0, 4'h0, 6'd7, 32'h0);
    tick();
    idle();
    tick();
    ev = '{1'b0, 1'b1, 1'b0};
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rvalid_a[d] !== ev[d] || rdata_a[d] !== 32'h20) begin
        errors++;
        $display("[TB] FAIL rdw_readback dut%0d got v=%0b d=%h exp v=%0b d=00000020",
                 d, rvalid_a[d], rdata_a[d], ev[d]);
      end
    end
  endtask

  task automatic test_collision();
    logic        ec [NDUT];
    logic [31:0] ed [NDUT];
    drive_a(1'b1, 1'b1, 4'hF, 6'd9, 32'h0);
    tick();
    drive_a(1'b1, 1'b1, 4'b0001, 6'd9, 32'h11);
    drive_b(1'b1, 1'b1, 4'b0001, 6'd9, 32'h22);
    tick();
    idle();
    ec = '{1'b1, 1'b0, 1'b1};
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (coll[d] !== ec[d] || coll_sticky[d] !== ec[d]) begin
        errors++;
        $display("[TB] FAIL coll_first dut%0d got c=%0b s=%0b exp c=%0b s=%0b",
                 d, coll[d], coll_sticky[d], ec[d], ec[d]);
      end
    end
    tick();
    ec = '{1'b0, 1'b1, 1'b0};
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (coll[d] !== ec[d] || coll_sticky[d] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL coll_second dut%0d got c=%0b s=%0b exp c=%0b s=1",
                 d, coll[d], coll_sticky[d], ec[d]);
      end
    end
    tick();
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (coll[d] !== 1'b0 || coll_sticky[d] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL coll_after dut%0d got c=%0b s=%0b exp c=0 s=1",
                 d, coll[d], coll_sticky[d]);
      end
    end
    drive_a(1'b1, 1'b0, 4'h0, 6'd9, 32'h0);
    tick();
    idle();
    tick();
    ed = '{32'h11, 32'h22, 32'h11};
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rdata_a[d] !== ed[d]) begin
        errors++;
        $display("[TB] FAIL coll_winner dut%0d got %h exp %h", d, rdata_a[d], ed[d]);
      end
    end
  endtask

  task automatic test_mixed_port();
    logic [31:0] ed [NDUT];
    drive_a(1'b1, 1'b1, 4'hF, 6'd2, 32'h33);
    tick();
    drive_a(1'b1, 1'b1, 4'hF, 6'd2, 32'h44);
    drive_b(1'b1, 1'b0, 4'h0, 6'd2, 32'h0);
    tick();
    drive_a(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
    for (int d = 0; d < NDUT; d += 2) begin
      checks++;
      if (rvalid_b[d] !== 1'b1 || rdata_b[d] !== 32'h33) begin
        errors++;
        $display("[TB] FAIL mixed_old dut%0d got v=%0b d=%h exp v=1 d=00000033",
                 d, rvalid_b[d], rdata_b[d]);
      end
    end
    tick();
    idle();
    ed = '{32'h44, 32'h33, 32'h44};
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rvalid_b[d] !== 1'b1 || rdata_b[d] !== ed[d]) begin
        errors++;
        $display("[TB] FAIL mixed_next dut%0d got v=%0b d=%h exp v=1 d=%h",
                 d, rvalid_b[d], rdata_b[d], ed[d]);
      end
    end
    tick();
    checks++;
    if (rdata_b[1] !== 32'h44) begin
      errors++;
      $display("[TB] FAIL mixed_next_lat2 dut1 got %h exp 00000044", rdata_b[1]);
    end
    drive_a(1'b1, 1'b1, 4'b0001, 6'd2, 32'h000000AA);
    drive_b(1'b1, 1'b1, 4'b0010, 6'd2, 32'h0000BB00);
    tick();
    idle();
    tick();
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (coll[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL disjoint_coll dut%0d got %0b exp 0", d, coll[d]);
      end
    end
    drive_a(1'b1, 1'b0, 4'h0, 6'd2, 32'h0);
    tick();
    idle();
    tick();
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rdata_a[d] !== 32'h0000BBAA || coll_sticky[d] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL disjoint_data dut%0d got d=%h s=%0b exp d=0000bbaa s=1",
                 d, rdata_a[d], coll_sticky[d]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic        ev [NDUT];
    logic [31:0] ed [NDUT];
    drive_a(1'b1, 1'b0, 4'h0, 6'd5, 32'h0);
    drive_b(1'b1, 1'b0, 4'h0, 6'd3, 32'h0);
    tick();
    checks++;
    if (rvalid_a[0] !== 1'b1 || rdata_a[0] !== 32'hA5) begin
      errors++;
      $display("[TB] FAIL stream_before_reset dut0 got v=%0b d=%h exp v=1 d=000000a5",
               rvalid_a[0], rdata_a[0]);
    end
    drive_a(1'b1, 1'b0, 4'h0, 6'd7, 32'h0);
    drive_b(1'b1, 1'b0, 4'h0, 6'd9, 32'h0);
    tick();
    reset = 1'b1;
    drive_a(1'b1, 1'b1, 4'hF, 6'd5, 32'hDEADBEEF);
    drive_b(1'b1, 1'b0, 4'h0, 6'd2, 32'h0);
    tick();
    test_reset();
    reset = 1'b0;
    idle();
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int d = 0; d < NDUT; d++) begin
        checks++;
        if ({rvalid_a[d], rvalid_b[d], coll[d]} !== 3'b000) begin
          errors++;
          $display("[TB] FAIL squashed dut%0d cycle%0d got %b exp 000", d, c,
                   {rvalid_a[d], rvalid_b[d], coll[d]});
        end
      end
    end
    drive_a(1'b1, 1'b0, 4'h0, 6'd5, 32'h0);
    drive_b(1'b1, 1'b0, 4'h0, 6'd3, 32'h0);
    tick();
    idle();
    ev = '{1'b1, 1'b0, 1'b1};
    ed = '{32'hA5, 32'h0, 32'hA5};
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rvalid_a[d] !== ev[d] || rdata_a[d] !== ed[d]) begin
        errors++;
        $display("[TB] FAIL preserved_a dut%0d got v=%0b d=%h exp v=%0b d=%h",
                 d, rvalid_a[d], rdata_a[d], ev[d], ed[d]);
      end
    end
    tick();
    checks++;
    if (rvalid_b[1] !== 1'b1 || rdata_a[1] !== 32'hA5 || rdata_b[1] !== 32'h11BB33DD) begin
      errors++;
      $display("[TB] FAIL preserved_lat2 dut1 got v=%0b a=%h b=%h exp v=1 a=000000a5 b=11bb33dd",
               rvalid_b[1], rdata_a[1], rdata_b[1]);
    end
    for (int d = 0; d < NDUT; d += 2) begin
      checks++;
      if (rdata_b[d] !== 32'h11BB33DD) begin
        errors++;
        $display("[TB] FAIL preserved_b dut%0d got %h exp 11bb33dd", d, rdata_b[d]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    test_latency();
    test_byte_enables();
    test_rdw_modes();
    test_collision();
    test_mixed_port();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
